instr_fetch_issue: RTL and testbench
====================================

// Module: instr_fetch_issue
// PURPOSE
//   Front end of the single-cycle core: holds the PC and fetches 32-bit words from instruction memory over a valid/ready request plus response-valid interface.
//   Decodes each word into opcode/Funct3/Funct7/RS1/RS2/RD/Imm_reg/Shamt/read_en/write_en, the field set the datapath top consumes.
//   Issues one decoded instruction at a time to the datapath over an issue_valid/issue_ready handshake. Accepts PC redirects from branch/jump resolution.
// PARAMETERS
//   WIDTH     32            datapath/address width
//   RESET_PC  32'h0000_0000 PC loaded on reset
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   rst            in   1      asynchronous, active-high reset
//   imem_req_valid out  1      fetch request valid
//   imem_req_ready in   1      instruction memory accepts request
//   imem_addr      out  WIDTH  fetch address (= pc)
//   imem_rsp_valid in   1      fetched word valid (1-cycle pulse)
//   imem_rsp_data  in   32     fetched instruction word
//   redirect_valid in   1      branch/jump taken
//   redirect_pc    in   WIDTH  new PC; bits [1:0] ignored (forced 0)
//   issue_valid    out  1      decoded instruction presented
//   issue_ready    in   1      datapath consumes instruction
//   pc             out  WIDTH  PC of presented instruction
//   opcode/Funct3/Funct7  out 7/3/7  instr[6:0]/[14:12]/[31:25]
//   RS1/RS2/RD     out  5 each instr[19:15]/[24:20]/[11:7]
//   Imm_reg        out  12     S-type {[31:25],[11:7]}, else instr[31:20]
//   Shamt          out  5      instr[24:20]
//   read_en/write_en out 1 each opcode==LOAD(0000011) / opcode==STORE(0100011)
//   illegal        out  1      sticky illegal-instruction flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async): state=IDLE, pc=RESET_PC, kill=0; every output 0 except imem_addr=RESET_PC.
//   - FSM: IDLE -> REQ (unconditionally, next cycle).
//     REQ: imem_req_valid=1; on req_ready -> WAIT.
//     WAIT: on rsp_valid, latch word -> ISSUE.
//     ISSUE: issue_valid=1, fields from latched word, held stable until issue_ready; on handshake pc+=4 (mod 2^WIDTH, wraps), -> REQ.
//   - Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, ISSUE each one cycle).
//   - rsp_valid outside WAIT is ignored. imem_addr is stable while req_valid=1.
//   - Redirect has priority in every state: pc<=redirect_pc&~3, next state REQ.
//     In WAIT: kill=1; next rsp_valid is dropped (clears kill); the new request is not raised until the killed response arrives.
//     Redirect together with an issue handshake: the instruction counts as consumed, pc takes redirect_pc (not pc+4).
//     Redirect in REQ together with req_ready: the request is abandoned as in WAIT (kill set).
//   - Decode is purely combinational from the latched word; all outputs are 0 whenever issue_valid=0.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined:
//     - In ISSUE, opcode[1:0]!=2'b11 or opcode not in {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP} -> illegal=1 (sticky).
//     - issue_valid stays 0 and state=HALT; HALT exits only on rst or redirect_valid (illegal then clears).
//   ILLEGAL_TRAP_EN undefined: illegal tied 0, no HALT state; every word is issued unchanged.
// STRUCTURE
//   - riscv_pkg: opcode localparams (OPC_LOAD, OPC_STORE, OPC_OP_IMM, ...), fetch FSM state encoding, INSTR_W=32.
//   - One sub-module, instr_field_decode: combinational word -> field outputs, read_en/write_en, and the legality bit.
//   - FSM, PC and kill flag stay in the top.
// TESTING
//   1. Reset, mem always ready, rsp 1 cycle later with 32'h00A00093 (addi x1,x0,10)
//      -> issue at pc=0 with opcode=0010011, RD=1, RS1=0, Imm_reg=12'h00A; next request addr=4.
//   2. Word 32'h00112223 (sw x1,4(x2)) -> write_en=1, read_en=0, RS1=2, RS2=1, Imm_reg=12'h004.
//      Hold issue_ready=0 for 5 cycles -> all fields stable, no new request raised.
//   3. redirect_valid with redirect_pc=32'h103 during WAIT
//      -> the in-flight response is dropped, no issue; next imem_addr=32'h100.
//   4. Redirect to 32'h40 in the same cycle as the issue handshake at pc=8 -> next imem_addr=32'h40, not 32'hC.
//   5. rst asserted mid-ISSUE -> outputs 0 immediately, not waiting for a clock edge; after release, first request addr=RESET_PC.
//   6. ILLEGAL_TRAP_EN, word 32'h0000_0000 -> illegal=1, no issue_valid, no further requests.
//      Then redirect to 32'h20 -> illegal=0, request addr=32'h20.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/issue front end: instruction width,
// RV32I base opcodes, fetch FSM state encoding and the opcode legality check.
// Optional build macro: ILLEGAL_TRAP_EN adds the HALT state used after an
// illegal instruction is seen.
package riscv_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;

    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE
`ifdef ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } fetch_state_t;

    // True for the base opcodes the datapath implements (all end in 2'b11).
    function automatic logic opcode_is_legal(input logic [OPC_W-1:0] op);
        logic known;
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: known = 1'b1;
            default:                                 known = 1'b0;
        endcase
        return known && (op[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction from a latched instruction word.
//   instr   : instruction word
//   valid   : word is being presented; every field output is 0 otherwise
//   opcode/Funct3/Funct7/RS1/RS2/RD/Imm_reg/Shamt : raw fields
//   read_en/write_en : LOAD / STORE opcode
//   legal   : opcode is a supported base opcode (not gated by valid)
module instr_field_decode
    import riscv_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               valid,
    output logic [6:0]         opcode,
    output logic [2:0]         Funct3,
    output logic [6:0]         Funct7,
    output logic [4:0]         RS1,
    output logic [4:0]         RS2,
    output logic [4:0]         RD,
    output logic [11:0]        Imm_reg,
    output logic [4:0]         Shamt,
    output logic               read_en,
    output logic               write_en,
    output logic               legal
);

    logic [OPC_W-1:0] op;

    assign op    = instr[6:0];
    assign legal = opcode_is_legal(op);

    // Field mux; S-type splits its immediate around rd.
    always_comb begin
        opcode   = '0;
        Funct3   = '0;
        Funct7   = '0;
        RS1      = '0;
        RS2      = '0;
        RD       = '0;
        Imm_reg  = '0;
        Shamt    = '0;
        read_en  = 1'b0;
        write_en = 1'b0;
        if (valid) begin
            opcode   = op;
            Funct3   = instr[14:12];
            Funct7   = instr[31:25];
            RS1      = instr[19:15];
            RS2      = instr[24:20];
            RD       = instr[11:7];
            Imm_reg  = (op == OPC_STORE) ? {instr[31:25], instr[11:7]} : instr[31:20];
            Shamt    = instr[24:20];
            read_en  = (op == OPC_LOAD);
            write_en = (op == OPC_STORE);
        end
    end

endmodule

// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: owns the PC, fetches one word at a time over a
// valid/ready request + response-valid memory port, decodes it and presents
// it to the datapath over issue_valid/issue_ready. Redirects win in every state.
//   clk, rst (async, active high)
//   imem_req_valid/imem_req_ready/imem_addr : fetch request (addr = pc)
//   imem_rsp_valid/imem_rsp_data            : fetched word (1-cycle pulse)
//   redirect_valid/redirect_pc              : branch/jump target (bits [1:0] dropped)
//   issue_valid/issue_ready, pc + decoded fields : presented instruction
//   illegal : sticky illegal-instruction flag
// Optional build macro: ILLEGAL_TRAP_EN (halt on illegal opcode; otherwise
// illegal is tied 0 and every word is issued).
module instr_fetch_issue
    import riscv_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_pc,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [WIDTH-1:0]   pc,
    output logic [6:0]         opcode,
    output logic [2:0]         Funct3,
    output logic [6:0]         Funct7,
    output logic [4:0]         RS1,
    output logic [4:0]         RS2,
    output logic [4:0]         RD,
    output logic [11:0]        Imm_reg,
    output logic [4:0]         Shamt,
    output logic               read_en,
    output logic               write_en,
    output logic               illegal
);

    fetch_state_t       state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic               kill_q, kill_d;
    logic               req_valid_c;
    logic               issue_valid_c;
    logic               word_legal;
    logic               issue_ok;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    assign issue_ok = word_legal;
    assign illegal  = illegal_q;
`else
    logic unused_legal;
    assign unused_legal = word_legal;
    assign issue_ok     = 1'b1;
    assign illegal      = 1'b0;
`endif

    // State, PC, latched word and kill flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            word_q    <= '0;
            kill_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            word_q    <= word_d;
            kill_q    <= kill_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        word_d        = word_q;
        kill_d        = kill_q;
        req_valid_c   = 1'b0;
        issue_valid_c = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d     = illegal_q;
`endif
        // The response of an abandoned request retires the kill flag whenever it lands.
        if (kill_q && imem_rsp_valid) begin
            kill_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                // Keep only one request outstanding: wait out a killed response first.
                req_valid_c = !kill_q;
                if (req_valid_c && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    word_d  = imem_rsp_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_ok) begin
                    issue_valid_c = 1'b1;
                    if (issue_ready) begin
                        pc_d    = pc_q + WIDTH'(4);
                        state_d = S_REQ;
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
`endif
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; a request already accepted by memory
        // and not yet answered must have its response discarded.
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~WIDTH'(3);
            state_d = S_REQ;
            if (((state_q == S_WAIT) && !imem_rsp_valid) || (req_valid_c && imem_req_ready)) begin
                kill_d = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            illegal_d = 1'b0;
`endif
        end
    end

    assign imem_req_valid = req_valid_c;
    assign imem_addr      = pc_q;
    assign issue_valid    = issue_valid_c;
    assign pc             = issue_valid_c ? pc_q : '0;

    instr_field_decode u_decode (
        .instr    (word_q),
        .valid    (issue_valid_c),
        .opcode   (opcode),
        .Funct3   (Funct3),
        .Funct7   (Funct7),
        .RS1      (RS1),
        .RS2      (RS2),
        .RD       (RD),
        .Imm_reg  (Imm_reg),
        .Shamt    (Shamt),
        .read_en  (read_en),
        .write_en (write_en),
        .legal    (word_legal)
    );

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: acts as instruction memory with configurable
// response latency and tracks the expected PC stream at the architectural
// level (sequential +4, redirect targets, one fetch outstanding).
module tb_instr_fetch_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [4:0]  RS1, RS2, RD;
    logic [11:0] Imm_reg;
    logic [4:0]  Shamt;
    logic        read_en, write_en, illegal;

    always #5 clk = ~clk;

    instr_fetch_issue #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .pc             (pc),
        .opcode         (opcode),
        .Funct3         (Funct3),
        .Funct7         (Funct7),
        .RS1            (RS1),
        .RS2            (RS2),
        .RD             (RD),
        .Imm_reg        (Imm_reg),
        .Shamt          (Shamt),
        .read_en        (read_en),
        .write_en       (write_en),
        .illegal        (illegal)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_issued = 0;
    int          issue_cyc = 0;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr [$];
    int          pend_due [$];
    logic [31:0] mem [logic [31:0]];
    logic        saw_req, saw_issue;
    logic [31:0] last_pc, last_req_addr;
    logic [50:0] last_fields;
    logic [50:0] dut_fields;
    logic [6:0]  legal_ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                   7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};

    assign dut_fields = {opcode, Funct3, Funct7, RS1, RS2, RD, Imm_reg, Shamt, read_en, write_en};

    // Memory image; unwritten locations hold "addi x1, x0, addr[13:2]".
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    // Field values of a word as the datapath should see them.
    function automatic logic [50:0] ref_dec(input logic [31:0] w);
        logic [6:0]  op;
        logic [11:0] imm;
        op  = w[6:0];
        imm = (op == 7'b0100011) ? {w[31:25], w[11:7]} : w[31:20];
        return {op, w[14:12], w[31:25], w[19:15], w[24:20], w[11:7], imm, w[24:20],
                op == 7'b0000011, op == 7'b0100011};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Caller sets
    // imem_req_ready / issue_ready / redirect_* beforehand.
    task automatic step();
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        saw_req       = imem_req_valid;
        saw_issue     = issue_valid;
        last_pc       = pc;
        last_req_addr = imem_addr;
        last_fields   = dut_fields;
        if (imem_req_valid) begin
            check("req_addr", 64'(imem_addr), 64'(exp_pc));
            check("one_outstanding", 64'(pend_addr.size()), 64'd0);
            if (imem_req_ready) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
            end
        end
        if (imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (issue_valid) begin
            check("issue_pc", 64'(pc), 64'(exp_pc));
            check("issue_fields", 64'(dut_fields), 64'(ref_dec(mem_word(exp_pc))));
            if (issue_ready) begin
                n_issued++;
                issue_cyc = cyc;
                if (!redirect_valid) exp_pc = exp_pc + 32'd4;
            end
        end else begin
            check("idle_zero", 64'({dut_fields, pc}), 64'd0);
        end
`ifndef ILLEGAL_TRAP_EN
        check("illegal_tied", 64'(illegal), 64'd0);
`endif
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!saw_issue && n < 40);
        check({tag, "_issue_seen"}, 64'(saw_issue), 64'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!saw_req && n < 40);
        check({tag, "_req_seen"}, 64'(saw_req), 64'd1);
    endtask

    initial begin
        int          prev;
        int          n0;
        logic [31:0] w;
        int          reqs, iss;

        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        issue_ready    = 1'b1;
        exp_pc         = 32'h0;
        mem[32'h0]     = 32'h00A00093;
        mem[32'h4]     = 32'h00112223;

        // Reset values
        #2;
        check("rst_outputs", 64'({imem_req_valid, issue_valid, illegal, dut_fields, pc}), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // 1: addi at pc 0, then next fetch at 4
        wait_issue("t1");
        check("t1_pc", 64'(last_pc), 64'h0);
        check("t1_fields", 64'(last_fields),
              64'({7'b0010011, 3'b000, 7'd0, 5'd0, 5'd10, 5'd1, 12'h00A, 5'd10, 1'b0, 1'b0}));
        issue_ready = 1'b0;
        wait_req("t1_next");
        check("t1_next_addr", 64'(last_req_addr), 64'h4);

        // 2: store at pc 4, held for 5 cycles
        wait_issue("t2");
        check("t2_fields", 64'(last_fields),
              64'({7'b0100011, 3'b010, 7'd0, 5'd2, 5'd1, 5'd4, 12'h004, 5'd1, 1'b0, 1'b1}));
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_hold_valid", 64'(saw_issue), 64'd1);
            check("t2_hold_fields", 64'(last_fields), 64'(ref_dec(32'h00112223)));
            check("t2_no_req", 64'(saw_req), 64'd0);
        end
        issue_ready = 1'b1;
        step();

        // 4: redirect coinciding with the issue handshake at pc 8
        issue_ready = 1'b0;
        wait_issue("t4");
        check("t4_pc", 64'(last_pc), 64'h8);
        issue_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        lat = 2;
        wait_req("t4_next");
        check("t4_next_addr", 64'(last_req_addr), 64'h40);

        // 3: redirect while waiting on memory; that response must be dropped
        n0             = n_issued;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        check("t3_wait_no_issue", 64'(saw_issue), 64'd0);
        redirect_valid = 1'b0;
        wait_req("t3_next");
        check("t3_next_addr", 64'(last_req_addr), 64'h100);
        check("t3_dropped", 64'(n_issued - n0), 64'd0);
        lat = 1;

        // 5: reset asserted mid-ISSUE clears outputs without a clock edge
        issue_ready = 1'b0;
        wait_issue("t5");
        check("t5_pre_issue", 64'(issue_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_outputs", 64'({issue_valid, imem_req_valid, dut_fields, pc}), 64'd0);
        check("t5_async_addr", 64'(imem_addr), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_pc = 32'h0;
        pend_addr.delete();
        pend_due.delete();
        issue_ready = 1'b1;
        wait_req("t5_after");
        check("t5_after_addr", 64'(last_req_addr), 64'h0);

        // Best-case throughput: one instruction every three cycles
        wait_issue("thru0");
        prev = issue_cyc;
        for (int k = 0; k < 3; k++) begin
            wait_issue("thru");
            check("thru_interval", 64'(issue_cyc - prev), 64'd3);
            prev = issue_cyc;
        end

        // PC wrap after a redirect taken while the request handshakes
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        wait_req("wrap_req");
        check("wrap_req_addr", 64'(last_req_addr), 64'hFFFF_FFFC);
        wait_issue("wrap_issue");
        check("wrap_issue_pc", 64'(last_pc), 64'hFFFF_FFFC);
        wait_req("wrap_next");
        check("wrap_next_addr", 64'(last_req_addr), 64'h0);

        // Randomized traffic against the PC-stream model
        for (int a = 32'h200; a < 32'h300; a += 4) begin
            w      = $urandom;
            w[6:0] = legal_ops[$urandom_range(0, 8)];
            mem[32'(a)] = w;
        end
        n0 = n_issued;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 9) < 7);
            lat            = $urandom_range(1, 3);
            issue_ready    = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'h200 + 32'($urandom_range(0, 255));
            step();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        issue_ready    = 1'b1;
        lat            = 1;
        check("rand_progress", 64'(n_issued - n0 > 20), 64'd1);

`ifdef ILLEGAL_TRAP_EN
        // 6: all-zero word traps and halts until redirected
        mem[32'h300]   = 32'h0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        wait_req("t6_req");
        check("t6_req_addr", 64'(last_req_addr), 64'h300);
        reqs = 0;
        iss  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            reqs += int'(saw_req);
            iss  += int'(saw_issue);
        end
        check("t6_illegal", 64'(illegal), 64'd1);
        check("t6_no_issue", 64'(iss), 64'd0);
        check("t6_no_req", 64'(reqs), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("t6_illegal_clear", 64'(illegal), 64'd0);
        wait_req("t6_after");
        check("t6_after_addr", 64'(last_req_addr), 64'h20);
`else
        reqs = 0;
        iss  = 0;
        check("trap_disabled", 64'({illegal, 31'(reqs), 32'(iss)}), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
